// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the IF/MEM unified-RAM arbiter.
// The state encoding and owner codes are fixed so both stages decode them identically.
package pipe_mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IF  = 2'd1,
    SERVE_MEM = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam int STARVE_W = 4;
  localparam int WAIT_W   = 8;

endpackage

// File: rtl/pipe_mem_arbiter_if.sv
// Bundles the fetch port, the load/store port and the RAM port of the arbiter.
// The arbiter uses the slave modport; the CPU/RAM environment uses the master modport.
interface pipe_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_ack;

  logic          stall_if;
  logic          stall_mem;
  logic          err;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
    output if_rdata, if_ready, mem_rdata, mem_ready,
           ram_req, ram_we, ram_addr, ram_wdata, stall_if, stall_mem, err
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
           ram_req, ram_we, ram_addr, ram_wdata, stall_if, stall_mem, err
  );

endinterface

// File: rtl/arb_wait_timer.sv
// Counts RAM wait cycles for the access in flight; expired flags a hung access.
module arb_wait_timer
  import pipe_mem_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  logic [WAIT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + WAIT_W'(1);
    end
  end

  assign o_expired = (r_cnt == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates the single-ported unified RAM between instruction fetch and load/store.
// MEM wins by default; after STARVE_LIMIT MEM grants with IF waiting, IF is forced through.
module pipe_mem_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_WAIT     = 15
) (
  input  logic                Clock,
  input  logic                Reset,
  pipe_mem_arbiter_if.slave   bus
);

  localparam logic [STARVE_W-1:0] LP_STARVE = STARVE_W'(STARVE_LIMIT);

  state_t                r_state;
  logic                  r_owner;
  logic [STARVE_W-1:0]   r_starve_cnt;
  logic                  r_ram_req;
  logic                  r_ram_we;
  logic [AW-1:0]         r_ram_addr;
  logic [DW-1:0]         r_ram_wdata;
  logic [DW-1:0]         r_if_rdata;
  logic [DW-1:0]         r_mem_rdata;
  logic                  r_if_ready;
  logic                  r_mem_ready;
  logic                  r_err;

  logic w_if_wins;
  logic w_serving;
  logic w_expired;
  logic w_timer_clear;
  logic w_timer_en;

  assign w_if_wins     = bus.if_req & (~bus.mem_req | (r_starve_cnt == LP_STARVE));
  assign w_serving     = (r_state == SERVE_IF) || (r_state == SERVE_MEM);
  assign w_timer_clear = (r_state == IDLE);
  assign w_timer_en    = w_serving & ~bus.ram_ack & ~w_expired;

  arb_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .i_clk     (Clock),
    .i_rst     (Reset),
    .i_clear   (w_timer_clear),
    .i_en      (w_timer_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_owner      <= OWN_IF;
      r_starve_cnt <= '0;
      r_ram_req    <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
      r_if_ready   <= 1'b0;
      r_mem_ready  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.if_req || bus.mem_req) begin
            r_ram_req <= 1'b1;
            if (w_if_wins) begin
              r_state      <= SERVE_IF;
              r_owner      <= OWN_IF;
              r_ram_we     <= 1'b0;
              r_ram_addr   <= bus.if_addr;
              r_ram_wdata  <= '0;
              r_starve_cnt <= '0;
            end else begin
              r_state     <= SERVE_MEM;
              r_owner     <= OWN_MEM;
              r_ram_we    <= bus.mem_we;
              r_ram_addr  <= bus.mem_addr;
              r_ram_wdata <= bus.mem_wdata;
              if (bus.if_req && (r_starve_cnt != LP_STARVE)) begin
                r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
              end
            end
          end
        end
        SERVE_IF, SERVE_MEM: begin
          if (bus.ram_ack) begin
            r_ram_req <= 1'b0;
            r_state   <= DONE;
            if (r_owner == OWN_IF) begin
              r_if_rdata <= bus.ram_rdata;
              r_if_ready <= 1'b1;
            end else begin
              // Stores leave the last load value visible to the MEM stage.
              if (!r_ram_we) begin
                r_mem_rdata <= bus.ram_rdata;
              end
              r_mem_ready <= 1'b1;
            end
          end else if (w_expired) begin
            r_ram_req <= 1'b0;
            r_state   <= DONE;
            r_err     <= 1'b1;
            if (r_owner == OWN_IF) begin
              r_if_rdata <= '0;
              r_if_ready <= 1'b1;
            end else begin
              r_mem_rdata <= '0;
              r_mem_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_req   = r_ram_req;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.if_ready  = r_if_ready;
  assign bus.mem_ready = r_mem_ready;
  assign bus.err       = r_err;

  // Combinational so the stage releases on the same edge that ends the ready cycle.
  assign bus.stall_if  = bus.if_req & ~r_if_ready;
  assign bus.stall_mem = bus.mem_req & ~r_mem_ready;

endmodule

// File: doc/pipe_mem_arbiter.md
# pipe_mem_arbiter

Shares one single-ported unified instruction/data RAM between the IF stage (instruction fetch) and the MEM stage (load/store) of the five-stage pipelined CPU. Each access runs as a req/ready handshake. The block drives a variable-latency RAM handshake and produces per-stage stall signals that the hazard logic ORs into the pipeline `stall`. Priority goes to the older instruction (MEM), and a starvation counter guarantees IF progress. A wait timer aborts hung RAM accesses.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `STARVE_LIMIT`, 4, consecutive MEM grants with IF pending before IF is forced to win (1..15)
- `MAX_WAIT`, 15, cycles `ram_req` may stay high without `ram_ack` before abort (1..255)

Ports:
- `Clock` in 1: single clock, rising edge
- `Reset` in 1: asynchronous, active-high reset
- `if_req` in 1: fetch request, held until `if_ready`
- `if_addr` in AW: fetch address
- `if_rdata` out DW: fetched instruction, valid when `if_ready`
- `if_ready` out 1: one-cycle completion pulse
- `mem_req` in 1: data request, held until `mem_ready`
- `mem_we` in 1: 1 = store, 0 = load
- `mem_addr` in AW: data address
- `mem_wdata` in DW: store data
- `mem_rdata` out DW: load data, valid when `mem_ready`
- `mem_ready` out 1: one-cycle completion pulse
- `ram_req` out 1: RAM request, held until `ram_ack`
- `ram_we` out 1: RAM write enable
- `ram_addr` out AW: RAM address
- `ram_wdata` out DW: RAM write data
- `ram_rdata` in DW: RAM read data, valid with `ram_ack`
- `ram_ack` in 1: RAM completion
- `stall_if` out 1: `if_req & ~if_ready`, combinational
- `stall_mem` out 1: `mem_req & ~mem_ready`, combinational
- `err` out 1: one-cycle pulse on timeout abort

## Operation
- FSM states: IDLE, SERVE_IF, SERVE_MEM, DONE.
- **IDLE, arbitration:**
  - `mem_req` wins, unless `if_req` is also high and `starve_cnt == STARVE_LIMIT`, in which case IF wins.
  - Transition to SERVE_x.
  - Latch the winner's addr, we, wdata into `ram_*` registers. IF requests always have `we = 0`.
- **SERVE_x:**
  - `ram_req = 1` with the latched fields held stable.
  - On `ram_ack`: capture `ram_rdata` into the owner's rdata register (loads and fetches only; stores leave `mem_rdata` unchanged), then go to DONE.
- **DONE:** the owner's `ready` pulses high for exactly one cycle, then return to IDLE. The DONE cycle never re-arbitrates.
- **starve_cnt** (4 bits):
  - +1 on each MEM grant while `if_req` is high.
  - Cleared on any IF grant.
  - Saturates at STARVE_LIMIT.
- **wait_cnt** (8 bits):
  - Cleared on entry to SERVE_x, +1 each SERVE cycle without ack.
  - When `wait_cnt == MAX_WAIT` with no ack: go to DONE, deliver rdata = 0, pulse `err` together with `ready`.
  - `ram_req` drops in DONE.
- Requester drops `req` mid-transaction: the transaction still completes on the RAM, and the `ready` pulse is issued (and ignored).
- `ram_ack` outside SERVE_x is ignored.

## Timing
- **Reset values (asynchronous, immediate):** state = IDLE; `ram_req`, `ram_we`, `if_ready`, `mem_ready`, `err` = 0; `ram_addr`, `ram_wdata`, `if_rdata`, `mem_rdata` = 0; both counters = 0.
- **Reset mid-SERVE:** `ram_req` deasserts in the same cycle. No ready pulse is issued for the aborted access.
- **Latency:** request seen in IDLE at cycle 0; `ram_req` high in cycle 1; ack at the earliest in cycle 1; ready in cycle 2; IDLE in cycle 3.
  - Minimum 3 cycles per access.
  - Throughput is one access per 3 cycles with a zero-wait RAM.
- **Stall signals:** `stall_if` and `stall_mem` are combinational, so the stage holds its pipeline register through the ready cycle and advances on the edge that ends it.
- **Simultaneous requests:** in IDLE, one requester is granted per arbitration. The loser's stall stays high, and it is granted in the next IDLE (at least 3 cycles later).

## Structure
- Package `pipe_mem_pkg`:
  - State encoding IDLE = 2'd0, SERVE_IF = 2'd1, SERVE_MEM = 2'd2, DONE = 2'd3.
  - Owner constants OWN_IF = 1'b0, OWN_MEM = 1'b1.
  - Counter widths.
- One sub-module, `arb_wait_timer`: a loadable 8-bit counter with clear, enable and `expired = (cnt == MAX_WAIT)`.
- Arbitration and the starvation counter stay in the top module.

## Test plan
- **Lone fetch:** `if_req`, addr 0x10, RAM acks in cycle 1 with 0x8C010000 → `ram_req` high cycle 1 only; `if_ready` cycle 2; `if_rdata` = 0x8C010000; `stall_if` low from cycle 3 after req drops.
- **Simultaneous:** `if_req` and `mem_req` (load 0x04) both high in cycle 0 → MEM granted first, `mem_ready` cycle 2; IF granted at cycle 3 IDLE, `if_ready` cycle 5.
- **Starvation:** `if_req` held high, `mem_req` re-issued every time → 4 MEM grants, then the 5th grant is IF; `starve_cnt` returns to 0.
- **Store:** `mem_we = 1`, addr 0x08, wdata 0xDEADBEEF, ack after 3 wait cycles → `ram_we = 1`, `ram_wdata` = 0xDEADBEEF stable for 4 cycles; `mem_ready` pulses; `mem_rdata` unchanged.
- **Timeout:** `ram_ack` never asserted → `ram_req` high for 16 cycles (`wait_cnt` 0..15), then `err` and `mem_ready` pulse together with `mem_rdata` = 0; FSM back in IDLE.
- **Reset mid-SERVE:** `Reset` asserted in cycle 1 of a fetch → `ram_req` = 0 immediately; no `if_ready`; after release, a new fetch completes normally.
